// File: rtl/serial_full_adder.sv
// Bit-serial adder: one full-adder cell with a registered carry, LSB first, WIDTH cycles per operation.
// Define SERIAL_ADDER_SUB_EN to add the sub port (a-b via inverted b and carry-in of 1).
module serial_full_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic             c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             s_bit;
    logic             c_next;
    logic [WIDTH-1:0] b_load;
    logic             c_load;

    // The full-adder cell this block feeds.
    assign s_bit  = sa_q[0] ^ sb_q[0] ^ c_q;
    assign c_next = (sa_q[0] & sb_q[0]) | (sa_q[0] & c_q) | (sb_q[0] & c_q);

`ifdef SERIAL_ADDER_SUB_EN
    assign b_load = sub ? ~b : b;
    assign c_load = sub ? 1'b1 : cin;
`else
    assign b_load = b;
    assign c_load = cin;
`endif

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        sr_d    = sr_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    sa_d    = a;
                    sb_d    = b_load;
                    c_d     = c_load;
                    cnt_d   = '0;
                    sr_d    = '0;
                end
            end
            S_RUN: begin
                sr_d  = {s_bit, sr_q[WIDTH-1:1]};
                sa_d  = {1'b0, sa_q[WIDTH-1:1]};
                sb_d  = {1'b0, sb_q[WIDTH-1:1]};
                c_d   = c_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d = S_DONE;
                    sum_d   = sr_d;
                    cout_d  = c_next;
                    // c_q here is the carry into the MSB, so no separate cprev flop is needed.
                    ovf_d   = c_q ^ c_next;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            sr_q    <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sr_q    <= sr_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule
